// File: rtl/adder_fifo_pkg.sv
// rtl/adder_fifo_pkg.sv - shared entry layout and sizing helpers for the adder result FIFO
package adder_fifo_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int ENTRY_W   = DEF_WIDTH + 2;
    localparam int SUM_LSB   = 0;
    localparam int COUT_BIT  = DEF_WIDTH;
    localparam int PAR_BIT   = DEF_WIDTH + 1;

    typedef struct packed {
        logic                 parity;
        logic                 cout;
        logic [DEF_WIDTH-1:0] sum;
    } entry_t;

    function automatic int entry_w(input int width);
        return width + 2;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W register array, synchronous write, combinational read
module fifo_mem #(
    parameter int DATA_W     = 6,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adder_result_fifo.sv
// rtl/adder_result_fifo.sv - result FIFO after the adder: pointers, occupancy, flags, registered dout
module adder_result_fifo
    import adder_fifo_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_LVL = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      sum_in,
    input  logic                  cout_in,
    input  logic                  parity_in,
    input  logic                  rd_en,
    output logic [WIDTH+1:0]      dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                EW        = entry_w(WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);

    if (clog2(DEPTH) != ADDR_WIDTH || (1 << ADDR_WIDTH) != DEPTH || DEPTH < 2) begin : g_bad_depth
        $error("adder_result_fifo: DEPTH must be a power of 2, >= 2, and equal 2**ADDR_WIDTH");
    end
    if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > DEPTH) begin : g_bad_af
        $error("adder_result_fifo: ALMOST_FULL_LVL must be within 1..DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [EW-1:0]         dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [EW-1:0]         wr_data;
    logic [EW-1:0]         rd_data;
    logic                  wr_acc;
    logic                  rd_acc;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);

    // Full/empty arbitration falls out of gating each side by its own flag.
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign wr_data = {parity_in, cout_in, sum_in};

    fifo_mem #(
        .DATA_W     (EW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = wr_en && full;
        underflow_d  = rd_en && empty;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            dout_d       = rd_data;
            dout_valid_d = 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb/tb_adder_result_fifo.sv - self-checking bench for adder_result_fifo against a queue model
module tb_adder_result_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] sum_in = '0;
    logic       cout_in = 1'b0;
    logic       parity_in = 1'b0;
    logic       rd_en = 1'b0;
    logic [5:0] dout;
    logic       dout_valid;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] q[$];
    logic [5:0] exp_dout  = '0;
    logic       exp_valid = 1'b0;
    logic       exp_ovf   = 1'b0;
    logic       exp_unf   = 1'b0;

    adder_result_fifo #(
        .WIDTH           (4),
        .DEPTH           (8),
        .ADDR_WIDTH      (3),
        .ALMOST_FULL_LVL (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .sum_in      (sum_in),
        .cout_in     (cout_in),
        .parity_in   (parity_in),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Advances one clock and updates the queue model from the inputs applied this cycle.
    task automatic cycle();
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        if (rst) begin
            q.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_ovf   = wr_en && was_full;
            exp_unf   = rd_en && was_empty;
            if (rd_en && !was_empty) begin
                exp_dout  = q.pop_front();
                exp_valid = 1'b1;
            end
            if (wr_en && !was_full) begin
                q.push_back({parity_in, cout_in, sum_in});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [5:0] d);
        {parity_in, cout_in, sum_in} = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        n_tests++; if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_tests++; if (full !== 1'b0)       begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_tests++; if (count !== 4'd0)      begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_tests++; if (dout !== 6'h00)      begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
        n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        n_tests++; if ({overflow, underflow, dout_valid} !== 3'b000)
            begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {overflow, underflow, dout_valid}); end
    endtask

    task automatic test_single();
        wr_en = 1'b1;
        set_data({1'b1, 1'b1, 4'hA});
        cycle();
        wr_en = 1'b0;
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count_wr got=%0d exp=1", count); end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        n_tests++; if (dout !== 6'b11_1010) begin n_fail++; $display("FAIL single_dout got=%b exp=111010", dout); end
        n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", dout_valid); end
        n_tests++; if (count !== 4'd0)      begin n_fail++; $display("FAIL single_count_rd got=%0d exp=0", count); end
        cycle();
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got=%b exp=0", dout_valid); end
        n_tests++; if (dout !== 6'b11_1010) begin n_fail++; $display("FAIL single_dout_hold got=%b exp=111010", dout); end
    endtask

    task automatic test_fill_overflow();
        logic [3:0] s;
        for (int i = 0; i < 9; i++) begin
            s = 4'(i);
            wr_en = 1'b1;
            set_data({^s, s[0], s});
            cycle();
            n_tests++; if (count !== 4'((i + 1 > 8) ? 8 : i + 1))
                begin n_fail++; $display("FAIL fill_count i=%0d got=%0d", i, count); end
            n_tests++; if (almost_full !== (i + 1 >= 6))
                begin n_fail++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i + 1 >= 6)); end
            n_tests++; if (full !== (i >= 7))
                begin n_fail++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i >= 7)); end
            n_tests++; if (overflow !== (i == 8))
                begin n_fail++; $display("FAIL fill_overflow i=%0d got=%b exp=%b", i, overflow, (i == 8)); end
        end
        wr_en = 1'b0;
        cycle();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_pulse got=%b exp=0", overflow); end
        for (int i = 0; i < 8; i++) begin
            s = 4'(i);
            rd_en = 1'b1;
            cycle();
            n_tests++; if (dout !== {^s, s[0], s} || dout_valid !== 1'b1)
                begin n_fail++; $display("FAIL drain i=%0d got=%h/%b exp=%h/1", i, dout, dout_valid, {^s, s[0], s}); end
        end
        rd_en = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        n_tests++; if (underflow !== 1'b1)  begin n_fail++; $display("FAIL underflow got=%b exp=1", underflow); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_valid got=%b exp=0", dout_valid); end
        n_tests++; if (dout !== exp_dout)   begin n_fail++; $display("FAIL underflow_dout got=%h exp=%h", dout, exp_dout); end
        n_tests++; if (count !== 4'd0)      begin n_fail++; $display("FAIL underflow_count got=%0d exp=0", count); end
        cycle();
        n_tests++; if (underflow !== 1'b0)  begin n_fail++; $display("FAIL underflow_pulse got=%b exp=0", underflow); end
    endtask

    task automatic test_simultaneous();
        logic [5:0] in_seq[$];
        logic [5:0] d;
        int j;
        j = 0;
        for (int i = 0; i < 3; i++) begin
            d = 6'($urandom);
            in_seq.push_back(d);
            wr_en = 1'b1;
            set_data(d);
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            d = 6'($urandom);
            in_seq.push_back(d);
            wr_en = 1'b1;
            rd_en = 1'b1;
            set_data(d);
            cycle();
            n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL simul_count i=%0d got=%0d exp=3", i, count); end
            n_tests++; if (dout !== in_seq[j] || dout_valid !== 1'b1)
                begin n_fail++; $display("FAIL simul_dout i=%0d got=%h exp=%h", i, dout, in_seq[j]); end
            j++;
        end
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 6'($urandom);
            in_seq.push_back(d);
            set_data(d);
            cycle();
        end
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_full got=%b exp=1", full); end
        rd_en = 1'b1;
        set_data(6'($urandom));
        cycle();
        wr_en = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_both_ovf got=%b exp=1", overflow); end
        n_tests++; if (count !== 4'd7)    begin n_fail++; $display("FAIL full_both_count got=%0d exp=7", count); end
        n_tests++; if (dout !== in_seq[j] || dout_valid !== 1'b1)
            begin n_fail++; $display("FAIL full_both_dout got=%h exp=%h", dout, in_seq[j]); end
        j++;
        for (int i = 0; i < 7; i++) begin
            cycle();
            n_tests++; if (dout !== in_seq[j]) begin n_fail++; $display("FAIL simul_drain i=%0d got=%h exp=%h", i, dout, in_seq[j]); end
            j++;
        end
        rd_en = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] d;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_data(6'($urandom));
            cycle();
        end
        n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL mid_prefill got=%0d exp=5", count); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wr_en = 1'b0;
        n_tests++; if (count !== 4'd0 || empty !== 1'b1)
            begin n_fail++; $display("FAIL mid_reset got=%0d/%b exp=0/1", count, empty); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ovf got=%b exp=0", overflow); end
        d = 6'h2D;
        wr_en = 1'b1;
        set_data(d);
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        n_tests++; if (dout !== d || dout_valid !== 1'b1 || count !== 4'd0)
            begin n_fail++; $display("FAIL mid_newdata got=%h/%b/%0d exp=%h/1/0", dout, dout_valid, count, d); end
    endtask

    task automatic test_random();
        int wb;
        for (int c = 0; c < 400; c++) begin
            wb = (c < 200) ? 70 : 35;
            rst   = ($urandom_range(0, 99) == 0);
            wr_en = ($urandom_range(0, 99) < wb);
            rd_en = ($urandom_range(0, 99) < (100 - wb));
            set_data(6'($urandom));
            cycle();
            n_tests++; if (count !== 4'(q.size()))
                begin n_fail++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, q.size()); end
            n_tests++; if (dout_valid !== exp_valid || (exp_valid && dout !== exp_dout))
                begin n_fail++; $display("FAIL rand_dout c=%0d got=%h/%b exp=%h/%b", c, dout, dout_valid, exp_dout, exp_valid); end
            n_tests++; if ({empty, full, almost_full} !== {q.size() == 0, q.size() == 8, q.size() >= 6})
                begin n_fail++; $display("FAIL rand_flags c=%0d got=%b size=%0d", c, {empty, full, almost_full}, q.size()); end
            n_tests++; if ({overflow, underflow} !== {exp_ovf, exp_unf})
                begin n_fail++; $display("FAIL rand_errs c=%0d got=%b exp=%b", c, {overflow, underflow}, {exp_ovf, exp_unf}); end
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_underflow();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
